// File: rtl/fft_result_reader.sv
// Drains the FFT result RAM in natural frequency order and streams the bins out on valid/ready.
// Reads are credit-limited so the small output FIFO can never overflow under backpressure.
module fft_result_reader #(
    parameter int N_POINTS    = 64,
    parameter int DATA_W      = 32,
    parameter int RD_LATENCY  = 1,
    parameter int BIT_REVERSE = 1,
    localparam int ADDR_W     = $clog2(N_POINTS),
    localparam int FIFO_DEPTH = RD_LATENCY + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              fft_idle_i,
    output logic              read_ram_o,
    output logic              ram_rd_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_index_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ISSUE, S_DRAIN} state_e;

    localparam logic [3:0]        DEPTH_C = 4'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(N_POINTS - 1);

    state_e              state_q;
    logic                arm_cnt_q;
    logic [ADDR_W-1:0]   rd_idx_q;
    logic                busy_q;
    logic                done_q;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]     pipe_idx_q [RD_LATENCY];

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_d  [FIFO_DEPTH];
    logic [3:0]        fifo_cnt_q, fifo_cnt_d;

    logic       push, pop, rd_en;
    logic [3:0] inflight, wr_pos;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < ADDR_W; i++) bitrev[i] = a[ADDR_W-1-i];
    endfunction

    assign push = pipe_vld_q[RD_LATENCY-1];
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + {3'b0, pipe_vld_q[i]};
    end

    // Credit check: a read may issue only if its data is sure to find a free FIFO slot.
    assign rd_en      = (state_q == S_ISSUE) && ((fifo_cnt_q + inflight) < (DEPTH_C + {3'b0, pop}));
    assign ram_rd_o   = rd_en;
    assign ram_addr_o = (BIT_REVERSE != 0) ? bitrev(rd_idx_q) : rd_idx_q;

    assign read_ram_o  = busy_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_valid_o = (fifo_cnt_q != 4'd0);
    assign out_data_o  = fifo_data_q[0];
    assign out_index_o = fifo_idx_q[0];
    assign out_last_o  = out_valid_o && (fifo_idx_q[0] == LAST_C);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            arm_cnt_q <= 1'b0;
            rd_idx_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i && fft_idle_i) begin
                    state_q   <= S_ARM;
                    arm_cnt_q <= 1'b0;
                    rd_idx_q  <= '0;
                    busy_q    <= 1'b1;
                end
                S_ARM: begin
                    arm_cnt_q <= 1'b1;
                    if (arm_cnt_q) state_q <= S_ISSUE;
                end
                S_ISSUE: if (rd_en) begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_C) state_q <= S_DRAIN;
                end
                S_DRAIN: if (pop && out_last_o) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_idx_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= rd_en;
            pipe_idx_q[0] <= rd_idx_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    // Shift-down FIFO: entry 0 is always the head, so the outputs come straight from flops.
    assign wr_pos = pop ? (fifo_cnt_q - 4'd1) : fifo_cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        fifo_cnt_d  = fifo_cnt_q + {3'b0, push} - {3'b0, pop};
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_idx_d[i]  = fifo_idx_q[i+1];
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (4'(i) == wr_pos)) begin
                fifo_data_d[i] = ram_rdata_i;
                fifo_idx_d[i]  = pipe_idx_q[RD_LATENCY-1];
            end
        end
    end

    // NOTE: the FIFO storage is reset because its head drives outputs that must read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_idx_q  <= fifo_idx_d;
        end
    end

endmodule

// File: doc/fft_result_reader.md
# fft_result_reader

Drains the FFT core's result memory after a transform completes and streams the N complex bins out over a valid/ready interface in natural frequency order. Holds the FFT controller's `read_ram_i` request high for the whole drain, so the controller parks in its read state and hands the memory port over. Generates bit-reversed RAM addresses, absorbs the fixed RAM read latency, and applies downstream backpressure through a small credit-controlled FIFO. Sits between the FFT core and the SoC-side result consumer (DMA or bus slave).

## Interface
Parameters:
- `N_POINTS`, 64: transform length; power of two, ≥ 4.
- `DATA_W`, 32: RAM word width (packed complex {re, im}); passed through unmodified.
- `RD_LATENCY`, 1: cycles from `ram_rd_o` to valid `ram_rdata_i`; range 1–3.
- `BIT_REVERSE`, 1: 1 means RAM address = bit-reverse(index); 0 means address = index.
- Derived: `ADDR_W` = log2(`N_POINTS`). `FIFO_DEPTH` = `RD_LATENCY` + 1.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  drain request; sampled only in IDLE.
- `fft_idle_i`  in  1  FFT controller idle; `start_i` is accepted only when this is high.
- `read_ram_o`  out  1  memory-ownership request to the FFT controller (its `read_ram_i`).
- `ram_rd_o`  out  1  RAM read strobe.
- `ram_addr_o`  out  `ADDR_W`  RAM read address.
- `ram_rdata_i`  in  `DATA_W`  RAM read data, valid `RD_LATENCY` cycles after `ram_rd_o`.
- `out_valid_o`  out  1  result beat valid.
- `out_ready_i`  in  1  consumer ready.
- `out_data_o`  out  `DATA_W`  bin value.
- `out_index_o`  out  `ADDR_W`  bin index k, natural order.
- `out_last_o`  out  1  high with the beat for k = `N_POINTS`-1.
- `busy_o`  out  1  high from start acceptance until the last beat is accepted.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- Reset values: every output is 0, state is IDLE, counters are 0, FIFO is empty, in-flight pipe is cleared.
- States:
  - IDLE: `start_i && fft_idle_i` → ARM. A start without `fft_idle_i` is dropped, not latched.
  - ARM: 2 cycles. `read_ram_o`=1 and no reads are issued; this lets the controller enter its read state and the memory mux switch. Then → ISSUE.
  - ISSUE: issue counter `rd_idx` runs 0..N-1. A read is issued when `occupancy + inflight - pop < FIFO_DEPTH`, where pop = `out_valid_o && out_ready_i` this cycle. After the read for `rd_idx` = N-1 is issued → DRAIN.
  - DRAIN: no further reads. Stay until the beat with `out_last_o` is accepted → IDLE.
- `ram_addr_o` = `BIT_REVERSE` ? bitrev(`rd_idx`) : `rd_idx`.
- Data path: a valid-shift pipe of depth `RD_LATENCY` tags returning data with its index. Returning data is always written into the FIFO; the credit rule guarantees the FIFO never overflows.
- FIFO: registered head drives `out_data_o`, `out_index_o` and `out_last_o`. `out_last_o` = (index == N-1).
- AXI-style hold: once `out_valid_o` is high, `out_data_o`, `out_index_o` and `out_last_o` stay stable until accepted.
- `read_ram_o` and `busy_o` are high in ARM, ISSUE and DRAIN.
- On the edge that accepts the last beat:
  - `read_ram_o` and `busy_o` drop.
  - `done_o` is 1 for the following cycle only.
- `start_i` is ignored while busy. A new start is accepted in IDLE, including the cycle `done_o` is high.
- Asynchronous reset mid-drain: everything returns to reset values immediately, and `read_ram_o` drops, which releases the controller. Pending data is discarded.

## Timing
- Cycle numbering: `start_i` is accepted in cycle 0.
- Cycles 1–2: ARM, `read_ram_o`=1.
- Cycle 3: first `ram_rd_o`, with `ram_addr_o`=0.
- With `out_ready_i` held high:
  - One read per cycle, in cycles 3..N+2.
  - First `out_valid_o` in cycle 4+`RD_LATENCY`.
  - One beat per cycle.
  - Last beat in cycle N+3+`RD_LATENCY`.
  - `done_o` in cycle N+4+`RD_LATENCY`.
- Full throughput is sustained at `FIFO_DEPTH` = `RD_LATENCY`+1.
- Under backpressure, occupancy plus in-flight reads never exceeds `FIFO_DEPTH`, and `ram_rd_o` stalls accordingly.

## Test plan
- Basic drain, N=64, `RD_LATENCY`=1, `BIT_REVERSE`=1, ready held high, RAM[a]=a:
  - Beats k=0..63 carry data bitrev6(k). For example k=1 → 32, k=3 → 48.
  - `out_last_o` only at k=63.
  - First valid in cycle 5; `done_o` in cycle 69.
  - `read_ram_o` high in cycles 1–68.
- Backpressure with `RD_LATENCY`=2 and random `out_ready_i` at 30% duty:
  - All 64 beats arrive in order with no loss or duplication.
  - `out_data_o` is stable while stalled.
  - The FIFO never exceeds 3 entries, checked by assertion.
- `BIT_REVERSE`=0, `RD_LATENCY`=3: `ram_addr_o` sequence is 0..63 and beat k carries RAM[k].
- Start gating:
  - `start_i` with `fft_idle_i`=0: no ARM and `read_ram_o` stays 0.
  - `start_i` pulsed again mid-drain: ignored, and the beat count stays 64.
- Reset asserted mid-ISSUE at beat 20: all outputs are 0 asynchronously. After release, a new start produces beats k=0..63 from the beginning.
- Back-to-back drains: `start_i` in the `done_o` cycle is accepted, and the second drain matches the first.
